systolic_feeder: RTL and testbench

Transmit-side counterpart to the result accumulator: it buffers a tile of input vectors and streams them into the systolic array rows with the diagonal skew the array expects. Each lane carries per-lane valid, and a done pulse marks the end of the tile. It sits between the host/unified-buffer write path and the array's west edge, mirroring the accumulator on the south edge.

---
 rtl/tpu_pkg.sv | 13 +
 rtl/systolic_feeder_if.sv | 29 ++
 rtl/feeder_tile_buf.sv | 32 +++
 rtl/systolic_feeder.sv | 127 ++++++++++++
 tb/tb_systolic_feeder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic array edge blocks.
package tpu_pkg;

  localparam int N_DEF      = 2;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Host-side load handshake plus skewed west-edge lane bus of the feeder.
interface systolic_feeder_if
  import tpu_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   in_data;
  logic                  in_last;
  logic                  start;
  logic                  busy;
  logic [N*DATA_W-1:0]   out_data;
  logic [N-1:0]          out_valid;
  logic                  done;

  modport master (
    output in_valid, in_data, in_last, start,
    input  in_ready, busy, out_data, out_valid, done
  );

  modport slave (
    input  in_valid, in_data, in_last, start,
    output in_ready, busy, out_data, out_valid, done
  );

endinterface

// File: rtl/feeder_tile_buf.sv
// Tile register file: one write port, one read port per lane returning that lane's element.
module feeder_tile_buf #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [N*DATA_W-1:0] wr_data,
  input  logic [N*AW-1:0]     rd_addr,
  output logic [N*DATA_W-1:0] rd_data
);

  logic [N*DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Each lane only ever needs its own column of the addressed vector.
  for (genvar gi = 0; gi < N; gi++) begin : g_rd
    assign rd_data[gi*DATA_W +: DATA_W] = mem_q[rd_addr[gi*AW +: AW]][gi*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one tile of input vectors and streams it diagonally skewed into the array rows.
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input logic              clk,
  input logic              reset,
  systolic_feeder_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(DEPTH + N) + 1;

  feeder_state_e       state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TW-1:0]       t_q, t_d;
  logic                in_ready_q, in_ready_d;
  logic                done_q, done_d;
  logic [N-1:0]        out_valid_q, out_valid_d;
  logic [N*DATA_W-1:0] out_data_q, out_data_d;

  logic                accept;
  logic [TW-1:0]       count_ext;
  logic [TW-1:0]       last_t;
  logic [N-1:0]        lane_hit;
  logic [N*AW-1:0]     rd_addr;
  logic [N*DATA_W-1:0] rd_data;

  assign accept    = (state_q == FILL) && bus.in_valid && in_ready_q;
  assign count_ext = TW'(count_q);
  // Final step carries no data; it is the cycle that registers done.
  assign last_t    = count_ext + TW'(N - 1);

  feeder_tile_buf #(
    .N      (N),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (bus.in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Lane gi reads vector t-gi; a negative or >= count index means the lane is idle.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [TW:0] diff;
    assign diff         = {1'b0, t_q} - (TW + 1)'(gi);
    assign lane_hit[gi] = (state_q == STREAM) && !diff[TW] && (diff[TW-1:0] < count_ext);
    assign rd_addr[gi*AW +: AW] = diff[AW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      t_q         <= '0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      t_q         <= t_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    t_d     = t_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          count_d = count_q + CW'(1);
          if (bus.in_last || (count_q == CW'(DEPTH - 1))) state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.start) begin
          state_d = STREAM;
          t_d     = '0;
        end
      end
      STREAM: begin
        if (t_q == last_t) begin
          state_d = FILL;
          count_d = '0;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == FILL) && (count_d < CW'(DEPTH));
    done_d      = (state_q == STREAM) && (t_q == last_t);
    out_valid_d = lane_hit;
    out_data_d  = '0;
    for (int i = 0; i < N; i++) begin
      if (lane_hit[i]) out_data_d[i*DATA_W +: DATA_W] = rd_data[i*DATA_W +: DATA_W];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = (state_q != FILL);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: scoreboard of per-cycle expected lane outputs.
module tb_systolic_feeder;

  localparam int N     = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    logic            done;
    logic            busy;
    logic            rdy;
  } exp_t;

  logic clk;
  logic reset;

  systolic_feeder_if #(.N(N), .DATA_W(DW)) bus ();

  systolic_feeder #(.N(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t            exp_q[$];
  logic [N*DW-1:0] tile_m[$];
  bit              closed;
  int              passed = 0;
  int              total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [N*DW-1:0] d, input logic last);
    bit acc;
    acc          = !closed && (tile_m.size() < DEPTH);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    check("in_ready_load", 64'(bus.in_ready), 64'(acc));
    if (acc) begin
      tile_m.push_back(d);
      if (last || tile_m.size() == DEPTH) closed = 1'b1;
    end
    $display("load data=%04h last=%0b accepted=%0b", d, last, acc);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  // Cycle 0 is the edge that samples start; lane i, vector j expected in cycle 1+i+j.
  task automatic run_stream(input int start_again, input int rst_at);
    int   cnt;
    int   ncyc;
    int   j;
    exp_t e;
    cnt  = tile_m.size();
    ncyc = cnt + N;
    for (int c = 0; c <= ncyc; c++) begin
      e.v = '0;
      e.d = '0;
      for (int i = 0; i < N; i++) begin
        j = c - 1 - i;
        if (j >= 0 && j < cnt) begin
          e.v[i]          = 1'b1;
          e.d[i*DW +: DW] = tile_m[j][i*DW +: DW];
        end
      end
      e.done = (c == ncyc);
      e.busy = (c != ncyc);
      e.rdy  = (c == ncyc);
      exp_q.push_back(e);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c <= ncyc; c++) begin
      e = exp_q.pop_front();
      $display("stream c%0d valid=%b data=%04h done=%0b (exp valid=%b data=%04h done=%0b)",
               c, bus.out_valid, bus.out_data, bus.done, e.v, e.d, e.done);
      check("out_valid", 64'(bus.out_valid), 64'(e.v));
      check("out_data",  64'(bus.out_data),  64'(e.d));
      check("done",      64'(bus.done),      64'(e.done));
      check("busy",      64'(bus.busy),      64'(e.busy));
      check("in_ready",  64'(bus.in_ready),  64'(e.rdy));
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data",  64'(bus.out_data),  64'(0));
        check("rst_busy",      64'(bus.busy),      64'(0));
        check("rst_done",      64'(bus.done),      64'(0));
        exp_q.delete();
        tile_m.delete();
        closed = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_in_ready_low", 64'(bus.in_ready), 64'(0));
        tick();
        check("rst_in_ready_rise", 64'(bus.in_ready), 64'(1));
        $display("reset applied mid-stream at c%0d", c);
        return;
      end
      bus.start = (c == start_again);
      if (c < ncyc) tick();
    end
    bus.start = 1'b0;
    tile_m.delete();
    closed = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.start    = 1'b0;
    closed       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready",  64'(bus.in_ready),  64'(0));
    check("reset_busy",      64'(bus.busy),      64'(0));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_out_data",  64'(bus.out_data),  64'(0));
    check("reset_done",      64'(bus.done),      64'(0));
    reset = 1'b0;
    tick();
    check("first_in_ready", 64'(bus.in_ready), 64'(1));

    // start while empty in FILL is ignored
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("fill_start_busy",     64'(bus.busy),     64'(0));
    check("fill_start_in_ready", 64'(bus.in_ready), 64'(1));

    // two-vector tile
    send(16'h0201, 1'b0);
    send(16'h0403, 1'b1);
    check("armed_busy",     64'(bus.busy),     64'(1));
    check("armed_in_ready", 64'(bus.in_ready), 64'(0));
    run_stream(-1, -1);

    // overfill: fifth vector refused
    send(16'h1211, 1'b0);
    send(16'h2221, 1'b0);
    send(16'h3231, 1'b0);
    send(16'h4241, 1'b0);
    send(16'h5251, 1'b0);
    run_stream(-1, -1);

    // start pulsed again mid-stream has no effect
    send(16'h6261, 1'b0);
    send(16'h7271, 1'b1);
    run_stream(1, -1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_done",      64'(bus.done),      64'(0));
      check("idle_busy",      64'(bus.busy),      64'(0));
      check("idle_out_valid", 64'(bus.out_valid), 64'(0));
    end

    // reset in cycle 2 of a stream
    send(16'h0201, 1'b0);
    send(16'h0403, 1'b1);
    run_stream(-1, 2);

    // single vector after reset proves count was cleared
    send(16'h0907, 1'b1);
    run_stream(-1, -1);

    // three-vector tile, then a one-vector tile loaded from the done cycle
    send(16'h0201, 1'b0);
    send(16'h0403, 1'b0);
    send(16'h0605, 1'b1);
    run_stream(-1, -1);
    send(16'h0808, 1'b1);
    run_stream(-1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
